dcache_req_arbiter: RTL
=======================

Name: dcache_req_arbiter

Overview:
- Shares the single dcache request/response port between two requesters.
- Port 0 is the load/store pipe. Port 1 is the secondary path (store-buffer drain / cacop-adjacent traffic).
- Accepts one request at a time, latches its payload, and sequences the dcache ready/rvalid handshake.
- Routes the registered response back to the owning requester. No second request is issued until the current transaction completes.

Parameters:
- AW, 32, address width
- DW, 32, data width; strobe width is DW/8

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- r0_valid  in  1  port 0 request valid; held until r0_ready
- r0_op  in  1  0 = read, 1 = write
- r0_addr  in  AW  physical address
- r0_wstrb  in  DW/8  byte strobes (write only)
- r0_wdata  in  DW  write data, already lane-aligned
- r0_ready  out  1  one-cycle pulse: request accepted/latched
- r0_rvalid  out  1  one-cycle pulse: read data valid
- r0_rdata  out  DW  read data, meaningful when r0_rvalid
- r0_wdone  out  1  one-cycle pulse: write accepted by dcache
- r1_valid, r1_op, r1_addr, r1_wstrb, r1_wdata, r1_ready, r1_rvalid, r1_rdata, r1_wdone  same as port 0
- dc_valid  out  1  request to dcache
- dc_op  out  1  0 = read, 1 = write
- dc_addr  out  AW  latched address
- dc_wstrb  out  DW/8  latched strobes
- dc_wdata  out  DW  latched write data
- dc_ready  in  1  dcache accepts request
- dc_rvalid  in  1  dcache read data valid
- dc_rdata  in  DW  dcache read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any time including mid-transaction):
  - State goes to IDLE.
  - All outputs are 0, including dc_valid, every ready/rvalid/wdone pulse, and rdata.
  - Latched payload and owner are cleared.
  - The dcache must tolerate abandonment of an in-flight request.
- States: IDLE, REQ, WAIT_R.
- IDLE:
  - If any rN_valid is high: pick a winner, latch op/addr/wstrb/wdata and the owner id, pulse rN_ready for the winner only, go to REQ.
  - The loser sees no ready and must keep holding its request.
- REQ:
  - dc_valid = 1, driven only from the latched registers.
  - If dc_ready and op = write: next cycle pulse wdone to the owner, go to IDLE.
  - If dc_ready and op = read and dc_rvalid in the same cycle: capture dc_rdata, pulse rvalid to the owner next cycle, go to IDLE.
  - If dc_ready and op = read without dc_rvalid: go to WAIT_R.
  - If no dc_ready: stay in REQ with the payload stable.
- WAIT_R:
  - dc_valid = 0.
  - On dc_rvalid: capture dc_rdata, pulse rvalid to the owner next cycle, go to IDLE.
- Responses are registered:
  - rN_rdata holds its last value until the next capture for that port.
  - The non-owner port never sees a pulse.
- Latency: accept at cycle N, dc_valid at N+1.
  - Minimum read: dc_ready and dc_rvalid at N+1 gives rvalid at N+2.
  - Minimum write: dc_ready at N+1 gives wdone at N+2.
- Back-to-back: a new acceptance may occur in the same cycle a response pulse is driven, because state is IDLE there. Minimum throughput is one transaction per 2 cycles.
- A requester dropping rN_valid after acceptance has no effect; the payload is already latched.
- dc_rvalid or dc_ready arriving in IDLE is ignored.
- Arbitration with the macro undefined is fixed priority: port 0 wins when both ports are valid.

Optional Feature:
- Macro: DCACHE_ARB_RR_EN.
- Defined:
  - Round-robin. A 1-bit last-grant register is updated on each acceptance; reset value is 1, so port 0 wins first.
  - With both ports valid, the port not granted last wins. A single valid port always wins.
- Undefined: fixed priority to port 0; no last-grant register exists.

Test Plan:
- Port 0 read at addr 0x1000_0040; dc_ready = 1 and dc_rvalid = 1 with rdata 0xDEADBEEF at the cycle after r0_ready -> r0_rvalid pulse one cycle later with r0_rdata = 0xDEADBEEF; r1 outputs stay 0.
- Port 1 write, addr 0x20, wstrb 4'b0011, wdata 0x0000_5A5A; dc_ready held 0 for 3 cycles -> dc_valid/dc_addr/dc_wstrb/dc_wdata stable for 4 cycles; r1_wdone one cycle after dc_ready.
- Port 0 read with dc_ready at cycle 1 and dc_rvalid at cycle 4 (rdata 0x1234_5678) -> WAIT_R for 3 cycles with dc_valid = 0; r0_rvalid with 0x1234_5678 follows.
- Both ports continuously valid, 4 transactions, macro undefined -> all 4 granted to port 0. Same run with DCACHE_ARB_RR_EN -> grants alternate 0, 1, 0, 1.
- Assert reset in WAIT_R -> dc_valid, busy, and all pulses read 0 immediately (async); after release a fresh r1 request is accepted normally.
- dc_rvalid = 1 while IDLE with no request -> no rvalid pulse on either port; rdata unchanged.

Source files
------------

// File: rtl/dcache_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_req_arbiter
//  Description : Shares one dcache request/response port between two
//                requesters. Port 0 is the load/store pipe, port 1 is the
//                secondary path (store-buffer drain / cacop-adjacent traffic).
//                One transaction is in flight at a time. The winning payload
//                is latched on acceptance and presented to the dcache from
//                registers. The registered response goes back to the owner
//                only.
//
//  Configuration macro:
//      DCACHE_ARB_RR_EN  - defined  : round-robin arbitration. A 1-bit
//                                     last-grant register resets to 1, so
//                                     port 0 wins first.
//                          undefined: fixed priority, port 0 wins ties.
//
//  Ports:
//      clk, reset            rising-edge clock, async active-high reset
//      rN_valid/op/addr/
//      rN_wstrb/wdata        request from port N; held until rN_ready
//      rN_ready              accept pulse (combinational, IDLE only)
//      rN_rvalid/rN_rdata    registered read response to port N
//      rN_wdone              registered write-complete pulse to port N
//      dc_*                  dcache request (latched) and response
//      busy                  high whenever the FSM is not in IDLE
//
//  Revision    : 1.0 - initial release
// ============================================================================

module dcache_req_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            r0_valid,
    input  logic            r0_op,
    input  logic [AW-1:0]   r0_addr,
    input  logic [DW/8-1:0] r0_wstrb,
    input  logic [DW-1:0]   r0_wdata,
    output logic            r0_ready,
    output logic            r0_rvalid,
    output logic [DW-1:0]   r0_rdata,
    output logic            r0_wdone,

    input  logic            r1_valid,
    input  logic            r1_op,
    input  logic [AW-1:0]   r1_addr,
    input  logic [DW/8-1:0] r1_wstrb,
    input  logic [DW-1:0]   r1_wdata,
    output logic            r1_ready,
    output logic            r1_rvalid,
    output logic [DW-1:0]   r1_rdata,
    output logic            r1_wdone,

    output logic            dc_valid,
    output logic            dc_op,
    output logic [AW-1:0]   dc_addr,
    output logic [DW/8-1:0] dc_wstrb,
    output logic [DW-1:0]   dc_wdata,
    input  logic            dc_ready,
    input  logic            dc_rvalid,
    input  logic [DW-1:0]   dc_rdata,

    output logic            busy
);

    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_owner;
    logic            r_op;
    logic [AW-1:0]   r_addr;
    logic [SW-1:0]   r_wstrb;
    logic [DW-1:0]   r_wdata;

    logic            w_accept;
    logic            w_win1;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
`ifdef DCACHE_ARB_RR_EN
    logic r_last_grant;

    // Port 1 wins when it is the only requester, or when both request and
    // port 0 was granted last.
    assign w_win1 = r1_valid && (!r0_valid || !r_last_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_win1;
        end
    end
`else
    assign w_win1 = r1_valid && !r0_valid;
`endif

    // Acceptance is a same-cycle handshake so that a request seen in IDLE
    // reaches the dcache on the very next cycle. Gating with reset keeps
    // the ready pulses low while reset is asserted.
    assign w_accept = !reset && (r_state == IDLE) && (r0_valid || r1_valid);
    assign r0_ready = w_accept && !w_win1;
    assign r1_ready = w_accept &&  w_win1;

    // ------------------------------------------------------------------------
    // Request side is driven only from the latched payload.
    // ------------------------------------------------------------------------
    assign dc_valid = (r_state == REQ);
    assign dc_op    = r_op;
    assign dc_addr  = r_addr;
    assign dc_wstrb = r_wstrb;
    assign dc_wdata = r_wdata;
    assign busy     = (r_state != IDLE);

    // ------------------------------------------------------------------------
    // Transaction FSM, payload latch and registered responses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_op      <= 1'b0;
            r_addr    <= '0;
            r_wstrb   <= '0;
            r_wdata   <= '0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_wdone  <= 1'b0;
            r1_wdone  <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            // Response signals are single-cycle pulses by default.
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_wdone  <= 1'b0;
            r1_wdone  <= 1'b0;

            case (r_state)
                IDLE: begin
                    // Stray dc_ready/dc_rvalid are ignored here.
                    if (w_accept) begin
                        r_owner <= w_win1;
                        if (w_win1) begin
                            r_op    <= r1_op;
                            r_addr  <= r1_addr;
                            r_wstrb <= r1_wstrb;
                            r_wdata <= r1_wdata;
                        end else begin
                            r_op    <= r0_op;
                            r_addr  <= r0_addr;
                            r_wstrb <= r0_wstrb;
                            r_wdata <= r0_wdata;
                        end
                        r_state <= REQ;
                    end
                end

                REQ: begin
                    if (dc_ready) begin
                        if (r_op) begin
                            if (r_owner) r1_wdone <= 1'b1;
                            else         r0_wdone <= 1'b1;
                            r_state <= IDLE;
                        end else if (dc_rvalid) begin
                            // Read data returned together with the accept.
                            if (r_owner) begin
                                r1_rdata  <= dc_rdata;
                                r1_rvalid <= 1'b1;
                            end else begin
                                r0_rdata  <= dc_rdata;
                                r0_rvalid <= 1'b1;
                            end
                            r_state <= IDLE;
                        end else begin
                            r_state <= WAIT_R;
                        end
                    end
                end

                WAIT_R: begin
                    if (dc_rvalid) begin
                        if (r_owner) begin
                            r1_rdata  <= dc_rdata;
                            r1_rvalid <= 1'b1;
                        end else begin
                            r0_rdata  <= dc_rdata;
                            r0_rvalid <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
